// File: rtl/jump_game_ctrl.sv
// Monster-jump game sequencer: button synchronisers, barrier tick scheduler with
// progressive speed-up, jump/crash FSM and 4-digit BCD score.
module jump_game_ctrl #(
   parameter logic [15:0] TICK_START    = 16'd50000,
   parameter logic [15:0] TICK_MIN      = 16'd10000,
   parameter logic [15:0] TICK_STEP     = 16'd2000,
   parameter int unsigned SPEEDUP_EVERY = 8,
   parameter int unsigned JUMP_TICKS    = 3,
   parameter int unsigned CRASH_HOLD    = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_start,
   input  logic        btn_jump,
   input  logic        col,
   output logic        up,
   output logic        b_tick,
   output logic        scroll_en,
   output logic        game_over,
   output logic [1:0]  state,
   output logic [15:0] score
);

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_AIR  = 2'b10;
   localparam logic [1:0] ST_OVER = 2'b11;

   localparam int unsigned SPEED_W = $clog2(SPEEDUP_EVERY + 1);
   localparam int unsigned AIR_W   = $clog2(JUMP_TICKS + 1);
   localparam int unsigned HOLD_W  = $clog2(CRASH_HOLD + 1);

   localparam logic [SPEED_W-1:0] SPEED_LAST = SPEED_W'(SPEEDUP_EVERY - 1);
   localparam logic [AIR_W-1:0]   AIR_LOAD   = AIR_W'(JUMP_TICKS);
   localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(CRASH_HOLD);

   // Smallest period that can still take a full step without dropping below the floor
   localparam logic [16:0] STEP_FLOOR = {1'b0, TICK_MIN} + {1'b0, TICK_STEP};

   logic start_s1_q, start_s2_q, start_prev_q;
   logic jump_s1_q, jump_s2_q, jump_prev_q;
   logic start_evt, jump_evt;

   logic [1:0]         state_q, state_d;
   logic [15:0]        score_q, score_d;
   logic [15:0]        period_q, period_d;
   logic [15:0]        tick_cnt_q, tick_cnt_d;
   logic [AIR_W-1:0]   air_cnt_q, air_cnt_d;
   logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic [SPEED_W-1:0] speed_cnt_q, speed_cnt_d;
   logic               b_tick_q, b_tick_d;
   logic               up_q, scroll_en_q, game_over_q;

   logic        wrap;
   logic        tick;
   logic [15:0] period_dec;

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         start_s1_q   <= 1'b0;
         start_s2_q   <= 1'b0;
         start_prev_q <= 1'b0;
         jump_s1_q    <= 1'b0;
         jump_s2_q    <= 1'b0;
         jump_prev_q  <= 1'b0;
      end else begin
         start_s1_q   <= btn_start;
         start_s2_q   <= start_s1_q;
         start_prev_q <= start_s2_q;
         jump_s1_q    <= btn_jump;
         jump_s2_q    <= jump_s1_q;
         jump_prev_q  <= jump_s2_q;
      end
   end

   assign start_evt = start_s2_q & ~start_prev_q;
   assign jump_evt  = jump_s2_q & ~jump_prev_q;

   assign wrap       = (tick_cnt_q == (period_q - 16'd1));
   assign tick       = wrap && ((state_q == ST_RUN) || (state_q == ST_AIR));
   assign period_dec = ({1'b0, period_q} >= STEP_FLOOR) ? (period_q - TICK_STEP) : TICK_MIN;

   always_comb begin
      state_d     = state_q;
      score_d     = score_q;
      period_d    = period_q;
      air_cnt_d   = air_cnt_q;
      hold_cnt_d  = hold_cnt_q;
      speed_cnt_d = speed_cnt_q;
      b_tick_d    = 1'b0;

      if (state_q == ST_IDLE) begin
         tick_cnt_d = '0;
      end else begin
         tick_cnt_d = wrap ? 16'd0 : (tick_cnt_q + 16'd1);
      end

      case (state_q)
         ST_IDLE: begin
            if (start_evt) begin
               state_d     = ST_RUN;
               score_d     = '0;
               tick_cnt_d  = '0;
               speed_cnt_d = '0;
               air_cnt_d   = '0;
               period_d    = TICK_START;
            end
         end
         ST_RUN, ST_AIR: begin
            if (col) begin
               // Collision wins over everything else happening this cycle
               state_d    = ST_OVER;
               hold_cnt_d = HOLD_LOAD;
            end else begin
               if (tick) begin
                  b_tick_d = 1'b1;
                  score_d  = bcd_inc(score_q);
                  if (speed_cnt_q == SPEED_LAST) begin
                     speed_cnt_d = '0;
                     period_d    = period_dec;
                  end else begin
                     speed_cnt_d = speed_cnt_q + 1'b1;
                  end
               end
               if (state_q == ST_RUN) begin
                  if (jump_evt) begin
                     state_d   = ST_AIR;
                     air_cnt_d = AIR_LOAD;
                  end
               end else if (tick) begin
                  if (air_cnt_q <= AIR_W'(1)) begin
                     state_d   = ST_RUN;
                     air_cnt_d = '0;
                  end else begin
                     air_cnt_d = air_cnt_q - 1'b1;
                  end
               end
            end
         end
         default: begin
            if (wrap && (hold_cnt_q != '0)) begin
               hold_cnt_d = hold_cnt_q - 1'b1;
            end
            if (start_evt && (hold_cnt_q == '0)) begin
               state_d     = ST_RUN;
               score_d     = '0;
               tick_cnt_d  = '0;
               speed_cnt_d = '0;
               air_cnt_d   = '0;
               period_d    = TICK_START;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         score_q     <= '0;
         period_q    <= TICK_START;
         tick_cnt_q  <= '0;
         air_cnt_q   <= '0;
         hold_cnt_q  <= '0;
         speed_cnt_q <= '0;
         b_tick_q    <= 1'b0;
         up_q        <= 1'b0;
         scroll_en_q <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         score_q     <= score_d;
         period_q    <= period_d;
         tick_cnt_q  <= tick_cnt_d;
         air_cnt_q   <= air_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         speed_cnt_q <= speed_cnt_d;
         b_tick_q    <= b_tick_d;
         up_q        <= (state_d == ST_AIR);
         scroll_en_q <= (state_d == ST_RUN) || (state_d == ST_AIR);
         game_over_q <= (state_d == ST_OVER);
      end
   end

   assign up        = up_q;
   assign b_tick    = b_tick_q;
   assign scroll_en = scroll_en_q;
   assign game_over = game_over_q;
   assign state     = state_q;
   assign score     = score_q;

endmodule
